sdram_avl_arbiter: RTL and testbench
====================================

Name: sdram_avl_arbiter

Overview:
- Two-master round-robin arbiter that shares the single SDRAM controller Avalon-MM slave port.
- Master 0 is the Nios II data master; master 1 is the profiling/trace DMA.
- Tracks outstanding pipelined reads so each readdatavalid is routed back to the master that issued the read.
- Sits in soc_system between both masters and sdram_controller_0.

Parameters:
- ADDR_W, 25, word address width (13 row + 10 col + 2 bank).
- DATA_W, 16, data width; matches SDRAM dq.
- MAX_PENDING, 8, outstanding-read depth; must be a power of two, ≥2.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous active-high reset.
- m_address, in, 2*ADDR_W, master addresses; master i uses slice [i*ADDR_W +: ADDR_W].
- m_read, in, 2, per-master read request.
- m_write, in, 2, per-master write request.
- m_writedata, in, 2*DATA_W, per-master write data.
- m_byteenable, in, 2*(DATA_W/8), per-master byte enables.
- m_waitrequest, out, 2, per-master stall.
- m_readdata, out, DATA_W, read data broadcast to both masters.
- m_readdatavalid, out, 2, per-master read-data valid.
- s_address, out, ADDR_W, address to SDRAM controller.
- s_read, out, 1, read command to SDRAM controller.
- s_write, out, 1, write command to SDRAM controller.
- s_writedata, out, DATA_W, write data to SDRAM controller.
- s_byteenable, out, DATA_W/8, byte enables to SDRAM controller.
- s_waitrequest, in, 1, controller stall.
- s_readdata, in, DATA_W, controller read data.
- s_readdatavalid, in, 1, controller read-data valid.
- err_rdv, out, 1, sticky: readdatavalid arrived with no reads outstanding.

Behaviour:
- Reset values:
  - Registered state: IDLE, grant=0, priority pointer=0, FIFO empty, err_rdv=0.
  - Combinational outputs while in reset/IDLE: s_read=s_write=0, m_waitrequest=2'b11, m_readdatavalid=0.
- Request: req[i] = m_read[i] | m_write[i]. Simultaneous m_read and m_write from one master is illegal; read takes precedence.
- FSM:
  - IDLE: if any req, pick the winner and register grant → GRANT.
  - Winner selection: single requester wins; if both request, the master ≠ last-accepted wins (round-robin).
  - GRANT: s_* driven combinationally from the granted master; m_waitrequest[granted] = s_waitrequest | rd_block; the other master's waitrequest = 1.
  - rd_block = m_read[granted] & fifo_full (registered full). While rd_block is high, s_read is forced to 0.
  - Accept = (s_read|s_write) & !s_waitrequest. On accept, update the priority pointer to the granted index.
  - After accept: if the other master is requesting, switch grant (stay in GRANT); else if the same master requests, keep grant (back-to-back, zero bubble); else → IDLE.
  - If the granted master drops its request without being accepted (protocol violation), → IDLE with no command issued.
- Latency: request in IDLE → s_read/s_write asserted 1 cycle later. Back-to-back accepted commands add no bubble.
- Read return:
  - On an accepted read, push the granted id into the ID FIFO.
  - On s_readdatavalid, pop the ID FIFO; m_readdatavalid[id] = 1 in the same cycle (combinational); m_readdata = s_readdata.
  - Responses are in order; no reordering.
- FIFO boundaries:
  - Push and pop in the same cycle leave the count unchanged.
  - While full, no push occurs even if a pop happens the same cycle, because the full flag is registered.
  - Writes are never blocked by a full FIFO.
- s_readdatavalid with an empty FIFO: no pop, no m_readdatavalid, err_rdv set; err_rdv clears only on reset.
- Reset mid-operation: all pending read ids are discarded. Late controller returns then set err_rdv; the system must reset the controller alongside the arbiter.

Optional Feature:
- Macro ARB_STATS_EN. When defined, adds these ports:
  - stat_clear, in, 1.
  - stat_grant, out, 64: two 32-bit counters of accepted commands, master 0 in the low half.
  - stat_stall, out, 64: per-master count of cycles with req & m_waitrequest.
- Counters saturate at 0xFFFFFFFF. stat_clear zeroes them on the next edge and has priority over increments in the same cycle.
- When the macro is undefined: the ports are absent and no counter logic is generated.

Decomposition:
- Package sdram_avl_arb_pkg holds:
  - FSM state enum {IDLE, GRANT}.
  - ID_W = 1, NUM_MASTERS = 2.
  - Stats counter width = 32 and saturation constant.
- Sub-module sdram_avl_arb_id_fifo: synchronous FIFO of ID_W-bit ids, depth MAX_PENDING, with registered full/empty flags and simultaneous push/pop.

Test Plan:
- Single write, M0 writes addr 0x000010, data 0x1234, s_waitrequest held 3 cycles → s_write held 4 cycles with stable address/data; m_waitrequest[0] deasserts in the accept cycle; m_waitrequest[1]=1 throughout.
- Fair interleave, both masters issue continuous writes → accepted grants alternate 0,1,0,1; the two stat_grant counters differ by at most 1 after 100 accepts (ARB_STATS_EN).
- Read routing, M0 reads 0x10, then M1 reads 0x20, then M0 reads 0x30, controller returns with latency 3 → m_readdatavalid pulses in the order 01,10,01 with matching data.
- FIFO full, 8 M1 reads with no returns → the 9th read stalls (s_read=0, m_waitrequest[1]=1); an M0 write is still accepted; the first return unblocks the 9th read the following cycle.
- Stray return, s_readdatavalid pulse with no reads outstanding → no m_readdatavalid, err_rdv=1 and stays set until reset.
- Async reset asserted mid-burst with 3 reads pending → outputs return to reset values immediately; after release, a new M0 read completes normally.

Source files
------------

// File: rtl/sdram_avl_arb_pkg.sv
// Shared types and constants for the two-master SDRAM Avalon-MM arbiter.
// Includes the saturating counter helper used when ARB_STATS_EN is defined.
package sdram_avl_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int ID_W        = 1;
    localparam int NUM_MASTERS = 2;
    localparam int STAT_W      = 32;
    localparam logic [STAT_W-1:0] STAT_SAT = 32'hFFFF_FFFF;

    // Clear wins over increment; the counter sticks at STAT_SAT.
    function automatic logic [STAT_W-1:0] stat_next(input logic [STAT_W-1:0] cnt,
                                                    input logic inc,
                                                    input logic clr);
        logic [STAT_W-1:0] nxt;
        if (clr) begin
            nxt = '0;
        end else if (inc && (cnt != STAT_SAT)) begin
            nxt = cnt + 32'd1;
        end else begin
            nxt = cnt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sdram_avl_arb_id_fifo.sv
// In-order FIFO of master ids for outstanding reads; full/empty are registered.
module sdram_avl_arb_id_fifo
    import sdram_avl_arb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [ID_W-1:0] push_id,
    input  logic            pop,
    output logic [ID_W-1:0] pop_id,
    output logic            full,
    output logic            empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ID_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic             push_ok, pop_ok;

    always_comb begin
        push_ok = push & ~full_q;
        pop_ok  = pop & ~empty_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == CNT_W'(0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_id;
        end
    end

    assign pop_id = mem_q[rd_ptr_q];
    assign full   = full_q;
    assign empty  = empty_q;

endmodule

// File: rtl/sdram_avl_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller Avalon-MM port between two masters.
// Optional ARB_STATS_EN adds saturating grant/stall counters per master.
module sdram_avl_arbiter
    import sdram_avl_arb_pkg::*;
#(
    parameter int ADDR_W      = 25,
    parameter int DATA_W      = 16,
    parameter int MAX_PENDING = 8
) (
    input  logic                    clk,
    input  logic                    reset,
`ifdef ARB_STATS_EN
    input  logic                    stat_clear,
    output logic [63:0]             stat_grant,
    output logic [63:0]             stat_stall,
`endif
    input  logic [2*ADDR_W-1:0]     m_address,
    input  logic [1:0]              m_read,
    input  logic [1:0]              m_write,
    input  logic [2*DATA_W-1:0]     m_writedata,
    input  logic [2*(DATA_W/8)-1:0] m_byteenable,
    output logic [1:0]              m_waitrequest,
    output logic [DATA_W-1:0]       m_readdata,
    output logic [1:0]              m_readdatavalid,
    output logic [ADDR_W-1:0]       s_address,
    output logic                    s_read,
    output logic                    s_write,
    output logic [DATA_W-1:0]       s_writedata,
    output logic [DATA_W/8-1:0]     s_byteenable,
    input  logic                    s_waitrequest,
    input  logic [DATA_W-1:0]       s_readdata,
    input  logic                    s_readdatavalid,
    output logic                    err_rdv
);

    localparam int BE_W = DATA_W / 8;

    arb_state_e      state_q, state_d;
    logic            grant_q, grant_d, prio_q, prio_d, err_rdv_q, err_rdv_d;
    logic [1:0]      req;
    logic            winner, rd_block, accept, push, pop;
    logic            fifo_full, fifo_empty;
    logic [ID_W-1:0] pop_id;

    always_comb begin
        req = m_read | m_write;
        if (req == 2'b11) begin
            winner = ~prio_q;
        end else if (req[1]) begin
            winner = 1'b1;
        end else begin
            winner = 1'b0;
        end

        state_d       = state_q;
        grant_d       = grant_q;
        prio_d        = prio_q;
        s_address     = '0;
        s_writedata   = '0;
        s_byteenable  = '0;
        s_read        = 1'b0;
        s_write       = 1'b0;
        m_waitrequest = 2'b11;
        rd_block      = 1'b0;
        accept        = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = winner;
                    state_d = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                s_address    = grant_q ? m_address[2*ADDR_W-1:ADDR_W] : m_address[ADDR_W-1:0];
                s_writedata  = grant_q ? m_writedata[2*DATA_W-1:DATA_W] : m_writedata[DATA_W-1:0];
                s_byteenable = grant_q ? m_byteenable[2*BE_W-1:BE_W] : m_byteenable[BE_W-1:0];
                rd_block     = m_read[grant_q] & fifo_full;
                s_read       = m_read[grant_q] & ~rd_block;
                s_write      = m_write[grant_q] & ~m_read[grant_q];
                accept       = (s_read | s_write) & ~s_waitrequest;
                m_waitrequest[grant_q] = s_waitrequest | rd_block;
                if (accept) begin
                    prio_d = grant_q;
                    if (req[~grant_q]) begin
                        grant_d = ~grant_q;
                    end else if (req[grant_q]) begin
                        grant_d = grant_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (!req[grant_q]) begin
                    state_d = IDLE;
                end else if (rd_block && req[~grant_q]) begin
                    // A read stalled on a full id FIFO must not lock out the other master.
                    grant_d = ~grant_q;
                end else begin
                    state_d = GRANT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        push      = accept & s_read;
        pop       = s_readdatavalid & ~fifo_empty;
        err_rdv_d = err_rdv_q | (s_readdatavalid & fifo_empty);
        m_readdatavalid = 2'b00;
        if (pop) begin
            m_readdatavalid[pop_id] = 1'b1;
        end else begin
            m_readdatavalid = 2'b00;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            prio_q    <= 1'b0;
            err_rdv_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            prio_q    <= prio_d;
            err_rdv_q <= err_rdv_d;
        end
    end

    sdram_avl_arb_id_fifo #(
        .DEPTH (MAX_PENDING)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (reset),
        .push    (push),
        .push_id (grant_q),
        .pop     (pop),
        .pop_id  (pop_id),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign m_readdata = s_readdata;
    assign err_rdv    = err_rdv_q;

`ifdef ARB_STATS_EN
    logic [STAT_W-1:0] grant_cnt_q [NUM_MASTERS];
    logic [STAT_W-1:0] grant_cnt_d [NUM_MASTERS];
    logic [STAT_W-1:0] stall_cnt_q [NUM_MASTERS];
    logic [STAT_W-1:0] stall_cnt_d [NUM_MASTERS];

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            grant_cnt_d[i] = stat_next(grant_cnt_q[i], accept & (grant_q == 1'(i)), stat_clear);
            stall_cnt_d[i] = stat_next(stall_cnt_q[i], req[i] & m_waitrequest[i], stat_clear);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                grant_cnt_q[i] <= '0;
                stall_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                grant_cnt_q[i] <= grant_cnt_d[i];
                stall_cnt_q[i] <= stall_cnt_d[i];
            end
        end
    end

    assign stat_grant = {grant_cnt_q[1], grant_cnt_q[0]};
    assign stat_stall = {stall_cnt_q[1], stall_cnt_q[0]};
`endif

endmodule

// File: tb/tb_sdram_avl_arbiter.sv
// Directed bench for sdram_avl_arbiter: per-cycle vector table plus hand-written corner sequences.
module tb_sdram_avl_arbiter;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic [2*ADDR_W-1:0] m_address;
    logic [1:0]          m_read, m_write;
    logic [2*DATA_W-1:0] m_writedata;
    logic [3:0]          m_byteenable;
    logic [1:0]          m_waitrequest, m_readdatavalid;
    logic [DATA_W-1:0]   m_readdata;
    logic [ADDR_W-1:0]   s_address;
    logic                s_read, s_write, s_waitrequest, s_readdatavalid, err_rdv;
    logic [DATA_W-1:0]   s_writedata, s_readdata;
    logic [1:0]          s_byteenable;
`ifdef ARB_STATS_EN
    logic                stat_clear = 1'b0;
    logic [63:0]         stat_grant, stat_stall;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sdram_avl_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PENDING(8)) dut (
        .clk             (clk),
        .reset           (reset),
`ifdef ARB_STATS_EN
        .stat_clear      (stat_clear),
        .stat_grant      (stat_grant),
        .stat_stall      (stat_stall),
`endif
        .m_address       (m_address),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .m_byteenable    (m_byteenable),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .s_address       (s_address),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_writedata     (s_writedata),
        .s_byteenable    (s_byteenable),
        .s_waitrequest   (s_waitrequest),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
        .err_rdv         (err_rdv)
    );

    typedef struct packed {
        logic [1:0] rd;
        logic [1:0] wr;
        logic       sw;
        logic       rdv;
        logic [1:0] e_mw;
        logic       e_sr;
        logic       e_sw;
        logic [1:0] e_mrdv;
        logic       e_g;
    } vec_t;

    vec_t vecs[$];

    logic [ADDR_W-1:0] exp_addr [2];
    logic [DATA_W-1:0] exp_wd   [2];
    logic [1:0]        exp_be   [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic [1:0] rd, input logic [1:0] wr, input logic sw,
                                input logic rdv, input logic [1:0] mw, input logic sr,
                                input logic swr, input logic [1:0] mrdv, input logic g);
        vecs.push_back({rd, wr, sw, rdv, mw, sr, swr, mrdv, g});
    endfunction

    initial begin
        int n;
        exp_addr[0] = 25'h000010; exp_addr[1] = 25'h000020;
        exp_wd[0]   = 16'h1234;   exp_wd[1]   = 16'h5678;
        exp_be[0]   = 2'b11;      exp_be[1]   = 2'b01;
        m_address    = {exp_addr[1], exp_addr[0]};
        m_writedata  = {exp_wd[1], exp_wd[0]};
        m_byteenable = {exp_be[1], exp_be[0]};
        m_read = 2'b00; m_write = 2'b00;
        s_waitrequest = 1'b0; s_readdatavalid = 1'b0; s_readdata = 16'h0000;
        reset = 1'b1;

        // single M0 write, controller stalls 3 cycles
        add(2'b00, 2'b01, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0);
        add(2'b00, 2'b01, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 2'b00, 1'b0);
        add(2'b00, 2'b01, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 2'b00, 1'b0);
        add(2'b00, 2'b01, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 2'b00, 1'b0);
        add(2'b00, 2'b01, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0);
        add(2'b00, 2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0);
        add(2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0);
        // both masters write continuously: grants alternate
        add(2'b00, 2'b11, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0);
        add(2'b00, 2'b11, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 2'b00, 1'b1);
        add(2'b00, 2'b11, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0);
        add(2'b00, 2'b11, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 2'b00, 1'b1);
        add(2'b00, 2'b11, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0);
        add(2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0);
        // read routing M0, M1, M0 with 3-cycle return latency
        add(2'b01, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0);
        add(2'b01, 2'b00, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0);
        add(2'b10, 2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0);
        add(2'b10, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0);
        add(2'b10, 2'b00, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1);
        add(2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0);
        add(2'b01, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0);
        add(2'b01, 2'b00, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 2'b10, 1'b0);
        add(2'b00, 2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0);
        add(2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0);
        add(2'b00, 2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 2'b01, 1'b0);
        add(2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0);
        // read and write together from M0: read wins
        add(2'b01, 2'b01, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0);
        add(2'b01, 2'b01, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0);
        add(2'b00, 2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0);
        add(2'b00, 2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 2'b01, 1'b0);
        add(2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0);

        // reset values
        #2;
        check("rst_mwait", m_waitrequest, 2'b11);
        check("rst_cmd", {s_read, s_write}, 2'b00);
        check("rst_mrdv", m_readdatavalid, 2'b00);
        check("rst_err", err_rdv, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        next_cycle();

        for (int i = 0; i < vecs.size(); i++) begin
            m_read = vecs[i].rd;
            m_write = vecs[i].wr;
            s_waitrequest = vecs[i].sw;
            s_readdatavalid = vecs[i].rdv;
            s_readdata = 16'hA000 + 16'(i);
            @(negedge clk);
            check($sformatf("v%0d_mwait", i), m_waitrequest, vecs[i].e_mw);
            check($sformatf("v%0d_cmd", i), {s_read, s_write}, {vecs[i].e_sr, vecs[i].e_sw});
            check($sformatf("v%0d_mrdv", i), m_readdatavalid, vecs[i].e_mrdv);
            if (vecs[i].e_sr || vecs[i].e_sw) begin
                check($sformatf("v%0d_addr", i), s_address, exp_addr[vecs[i].e_g]);
            end
            if (vecs[i].e_sw) begin
                check($sformatf("v%0d_wdata", i), {s_writedata, s_byteenable},
                      {exp_wd[vecs[i].e_g], exp_be[vecs[i].e_g]});
            end
            if (vecs[i].e_mrdv != 2'b00) begin
                check($sformatf("v%0d_rdata", i), m_readdata, 16'hA000 + 16'(i));
            end
            next_cycle();
        end
        s_readdatavalid = 1'b0;
        check("tbl_err", err_rdv, 1'b0);
`ifdef ARB_STATS_EN
        check("stat_grant", stat_grant, {32'd3, 32'd6});
`endif

        // FIFO full: 8 M1 reads with no returns
        m_read = 2'b10;
        n = 0;
        for (int c = 0; c < 40 && n < 8; c++) begin
            @(negedge clk);
            if (s_read && !s_waitrequest) n++;
            next_cycle();
        end
        check("fill_accepts", n, 8);
        m_write = 2'b01;
        @(negedge clk);
        check("full_block_sread", s_read, 1'b0);
        check("full_block_mwait", m_waitrequest, 2'b11);
        next_cycle();
        @(negedge clk);
        check("full_m0_write", {s_write, m_waitrequest}, {1'b1, 2'b10});
        check("full_m0_addr", s_address, exp_addr[0]);
        next_cycle();
        m_write = 2'b00;
        s_readdatavalid = 1'b1;
        s_readdata = 16'hBEEF;
        @(negedge clk);
        check("full_pop_mrdv", m_readdatavalid, 2'b10);
        check("full_pop_data", m_readdata, 16'hBEEF);
        check("full_still_blocked", s_read, 1'b0);
        next_cycle();
        s_readdatavalid = 1'b0;
        @(negedge clk);
        check("unblock_read", {s_read, m_waitrequest}, {1'b1, 2'b01});
        next_cycle();
        m_read = 2'b00;
        next_cycle();
        for (int k = 0; k < 8; k++) begin
            s_readdatavalid = 1'b1;
            @(negedge clk);
            check($sformatf("drain%0d", k), m_readdatavalid, 2'b10);
            next_cycle();
        end

        // stray return on an empty FIFO
        @(negedge clk);
        check("stray_no_rdv", m_readdatavalid, 2'b00);
        check("stray_err_pre", err_rdv, 1'b0);
        next_cycle();
        s_readdatavalid = 1'b0;
        @(negedge clk);
        check("stray_err_set", err_rdv, 1'b1);
        repeat (3) next_cycle();
        check("stray_err_sticky", err_rdv, 1'b1);

        // async reset with 3 M0 reads pending
        m_read = 2'b01;
        n = 0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            @(negedge clk);
            if (s_read && !s_waitrequest) n++;
            next_cycle();
        end
        check("pend_accepts", n, 3);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_mwait", m_waitrequest, 2'b11);
        check("mid_rst_cmd", {s_read, s_write}, 2'b00);
        check("mid_rst_err", err_rdv, 1'b0);
        m_read = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        next_cycle();
        m_read = 2'b01;
        @(negedge clk);
        check("post_rst_idle", m_waitrequest, 2'b11);
        next_cycle();
        @(negedge clk);
        check("post_rst_read", {s_read, m_waitrequest}, {1'b1, 2'b10});
        next_cycle();
        m_read = 2'b00;
        next_cycle();
        s_readdatavalid = 1'b1;
        s_readdata = 16'hC0DE;
        @(negedge clk);
        check("post_rst_mrdv", m_readdatavalid, 2'b01);
        check("post_rst_data", m_readdata, 16'hC0DE);
        next_cycle();
        s_readdatavalid = 1'b0;
        @(negedge clk);
        check("post_rst_err", err_rdv, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
